// File: rtl/seq_pkg.sv
// Shared types and helpers for the step sequencer: FSM state encoding,
// synchroniser depth, and the sensor-select field extractor.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FAULT} seq_state_e;

  localparam int SYNC_DEPTH = 2;

  // Returns the sel_w-bit field for step idx from a packed sensor map.
  function automatic int sensor_field(input logic [255:0] sel_map, input int idx,
                                      input int sel_w);
    int res;
    res = 0;
    for (int b = 0; b < 8; b++) begin
      if (b < sel_w && sel_map[idx*sel_w + b]) res = res | (1 << b);
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output follows
// the synchronised input only after it has differed for DEB_CYCLES edges.
module seq_debounce
  import seq_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  deb_q, deb_d;

  // Down-counter reloads whenever the input agrees; terminal count flips the level.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], din};
    deb_d  = deb_q;
    cnt_d  = CNT_LOAD;
    if (sync_q[SYNC_DEPTH-1] != deb_q) begin
      if (cnt_q == '0) deb_d = sync_q[SYNC_DEPTH-1];
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      sync_q <= '0;
      cnt_q  <= CNT_LOAD;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/step_sequencer.sv
// One-hot electro-pneumatic step sequencer with home interlock, pause/resume
// and continuous mode; SEQ_TIMEOUT_EN adds a per-step watchdog and FAULT state.
//
// state | meaning
// IDLE  | waiting for START with home sensors met
// RUN   | driving coil STEP_IDX until its sensor confirms
// PAUSE | coils off, step and watchdog retained
// FAULT | watchdog expired, coils off until STOP_RESUME
module step_sequencer
  import seq_pkg::*;
#(
  parameter int N_STEPS = 4,
  parameter int N_SENS  = 4,
  parameter int SEL_W   = $clog2(N_SENS),
  parameter logic [N_STEPS*SEL_W-1:0] STEP_SENSOR = 8'b10_00_11_01,
  parameter logic [N_SENS-1:0] HOME_MASK = 4'b0101,
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic                       STOP_RESUME,
  input  logic                       CONTINUOUS,
  input  logic [N_SENS-1:0]          SENS,
  output logic [N_STEPS-1:0]         STEP_Q,
  output logic [$clog2(N_STEPS)-1:0] STEP_IDX,
  output logic                       BUSY,
  output logic                       PAUSED,
  output logic                       DONE,
  output logic                       FAULT
);

  localparam int IDX_W = $clog2(N_STEPS);

  logic [N_SENS+1:0] raw_in, deb_all;
  logic [N_SENS-1:0] deb_sens;
  logic              start_lvl, stop_lvl, start_edge, stop_edge;
  logic [1:0]        btn_prev_q, btn_prev_d;
  logic [SEL_W-1:0]  sel_tab [N_STEPS];
  logic              sens_hit, home_ok, last_step;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_STEPS-1:0] step_q_q, step_q_d;
  logic              busy_q, busy_d, paused_q, paused_d, done_q, done_d;

  assign raw_in = {STOP_RESUME, START, SENS};

  for (genvar g = 0; g < N_SENS + 2; g++) begin : g_deb
    seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_sys (CLK),
      .rst_b   (RESET),
      .din     (raw_in[g]),
      .dout    (deb_all[g])
    );
  end

  for (genvar s = 0; s < N_STEPS; s++) begin : g_sel
    assign sel_tab[s] = SEL_W'(sensor_field(256'(STEP_SENSOR), s, SEL_W));
  end

  assign deb_sens   = deb_all[N_SENS-1:0];
  assign start_lvl  = deb_all[N_SENS];
  assign stop_lvl   = deb_all[N_SENS+1];
  assign btn_prev_d = {stop_lvl, start_lvl};
  assign start_edge = start_lvl & ~btn_prev_q[0];
  assign stop_edge  = stop_lvl & ~btn_prev_q[1];
  assign sens_hit   = deb_sens[sel_tab[idx_q]];
  assign home_ok    = (deb_sens & HOME_MASK) == HOME_MASK;
  assign last_step  = idx_q == IDX_W'(N_STEPS - 1);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_edge && home_ok) begin
          state_d = RUN;
          idx_d   = '0;
`ifdef SEQ_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      RUN: begin
        // Pause takes priority over a simultaneous sensor confirmation.
        if (stop_edge) begin
          state_d = PAUSE;
        end else if (sens_hit) begin
`ifdef SEQ_TIMEOUT_EN
          wd_d = '0;
`endif
          if (last_step) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (!CONTINUOUS) state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_q == WD_LAST) state_d = seq_pkg::FAULT;
        else                      wd_d    = wd_q + WD_W'(1);
`endif
      end
      PAUSE: begin
        if (stop_edge) state_d = RUN;
      end
`ifdef SEQ_TIMEOUT_EN
      seq_pkg::FAULT: begin
        if (stop_edge) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    step_q_d = (state_d == RUN) ? (N_STEPS'(1) << idx_d) : '0;
    busy_d   = (state_d == RUN) || (state_d == PAUSE);
    paused_d = (state_d == PAUSE);
`ifdef SEQ_TIMEOUT_EN
    fault_d  = (state_d == seq_pkg::FAULT);
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      btn_prev_q <= '0;
      step_q_q   <= '0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      btn_prev_q <= btn_prev_d;
      step_q_q   <= step_q_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
      done_q     <= done_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end
  assign FAULT = fault_q;
`else
  assign FAULT = 1'b0;
`endif

  assign STEP_Q   = step_q_q;
  assign STEP_IDX = idx_q;
  assign BUSY     = busy_q;
  assign PAUSED   = paused_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with DEB_CYCLES=4; the watchdog scenario
// runs only when SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES=50).
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop_resume = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] sens = 4'b0000;
  logic [3:0] step_q;
  logic [1:0] step_idx;
  logic       busy, paused, done, fault;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  step_sequencer #(
    .N_STEPS        (4),
    .N_SENS         (4),
    .STEP_SENSOR    (8'b10_00_11_01),
    .HOME_MASK      (4'b0101),
    .DEB_CYCLES     (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .START       (start),
    .STOP_RESUME (stop_resume),
    .CONTINUOUS  (continuous),
    .SENS        (sens),
    .STEP_Q      (step_q),
    .STEP_IDX    (step_idx),
    .BUSY        (busy),
    .PAUSED      (paused),
    .DONE        (done),
    .FAULT       (fault)
  );

  // Output bundle: {STEP_Q[3:0], STEP_IDX[1:0], BUSY, PAUSED, DONE, FAULT}
  function automatic logic [9:0] outs();
    return {step_q, step_idx, busy, paused, done, fault};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL reset: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
    rst_n = 1'b1;
    sens  = 4'b0101;
    tick(10);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL idle_after_reset: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
  endtask

  task automatic test_single_cycle();
    continuous = 1'b0;
    start = 1'b1;
    tick(6);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL start_early: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
    tick(1);
    n_vec++;
    if (outs() !== 10'b0001_00_1_0_0_0) begin
      n_miss++; $display("FAIL start_run: got %b want %b", outs(), 10'b0001_00_1_0_0_0);
    end
    start = 1'b0;
    sens  = 4'b0110;
    tick(6);
    n_vec++;
    if (outs() !== 10'b0001_00_1_0_0_0) begin
      n_miss++; $display("FAIL step0_hold: got %b want %b", outs(), 10'b0001_00_1_0_0_0);
    end
    tick(1);
    n_vec++;
    if (outs() !== 10'b0010_01_1_0_0_0) begin
      n_miss++; $display("FAIL step1: got %b want %b", outs(), 10'b0010_01_1_0_0_0);
    end
    sens = 4'b1010;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0100_10_1_0_0_0) begin
      n_miss++; $display("FAIL step2: got %b want %b", outs(), 10'b0100_10_1_0_0_0);
    end
    sens = 4'b1001;
    tick(7);
    n_vec++;
    if (outs() !== 10'b1000_11_1_0_0_0) begin
      n_miss++; $display("FAIL step3: got %b want %b", outs(), 10'b1000_11_1_0_0_0);
    end
    sens = 4'b0101;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_1_0) begin
      n_miss++; $display("FAIL done_idle: got %b want %b", outs(), 10'b0000_00_0_0_1_0);
    end
    tick(1);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL done_one_cycle: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
  endtask

  task automatic test_no_home();
    sens = 4'b0001;
    tick(10);
    start = 1'b1;
    tick(12);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL no_home: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
    start = 1'b0;
    tick(10);
    sens = 4'b0101;
    tick(10);
  endtask

  task automatic test_pause();
    start = 1'b1;
    tick(7);
    start = 1'b0;
    sens  = 4'b0110;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0010_01_1_0_0_0) begin
      n_miss++; $display("FAIL pause_pre: got %b want %b", outs(), 10'b0010_01_1_0_0_0);
    end
    stop_resume = 1'b1;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0000_01_1_1_0_0) begin
      n_miss++; $display("FAIL pause: got %b want %b", outs(), 10'b0000_01_1_1_0_0);
    end
    stop_resume = 1'b0;
    sens = 4'b1010;
    tick(10);
    n_vec++;
    if (outs() !== 10'b0000_01_1_1_0_0) begin
      n_miss++; $display("FAIL pause_hold: got %b want %b", outs(), 10'b0000_01_1_1_0_0);
    end
    stop_resume = 1'b1;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0010_01_1_0_0_0) begin
      n_miss++; $display("FAIL resume: got %b want %b", outs(), 10'b0010_01_1_0_0_0);
    end
    tick(1);
    n_vec++;
    if (outs() !== 10'b0100_10_1_0_0_0) begin
      n_miss++; $display("FAIL resume_advance: got %b want %b", outs(), 10'b0100_10_1_0_0_0);
    end
    stop_resume = 1'b0;
    sens = 4'b1001;
    tick(7);
    sens = 4'b0101;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_1_0) begin
      n_miss++; $display("FAIL pause_cycle_done: got %b want %b", outs(), 10'b0000_00_0_0_1_0);
    end
    tick(10);
  endtask

  task automatic test_continuous();
    continuous = 1'b1;
    start = 1'b1;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0001_00_1_0_0_0) begin
      n_miss++; $display("FAIL cont_start: got %b want %b", outs(), 10'b0001_00_1_0_0_0);
    end
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sens = 4'b0110;
      tick(7);
      n_vec++;
      if (outs() !== 10'b0010_01_1_0_0_0) begin
        n_miss++; $display("FAIL cont_step1 c%0d: got %b want %b", c, outs(), 10'b0010_01_1_0_0_0);
      end
      sens = 4'b1010;
      tick(7);
      sens = 4'b1001;
      tick(7);
      n_vec++;
      if (outs() !== 10'b1000_11_1_0_0_0) begin
        n_miss++; $display("FAIL cont_step3 c%0d: got %b want %b", c, outs(), 10'b1000_11_1_0_0_0);
      end
      sens = 4'b0101;
      tick(7);
      n_vec++;
      if (outs() !== 10'b0001_00_1_0_1_0) begin
        n_miss++; $display("FAIL cont_wrap c%0d: got %b want %b", c, outs(), 10'b0001_00_1_0_1_0);
      end
      tick(1);
      n_vec++;
      if (outs() !== 10'b0001_00_1_0_0_0) begin
        n_miss++; $display("FAIL cont_wrap_clear c%0d: got %b want %b", c, outs(), 10'b0001_00_1_0_0_0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    sens = 4'b0110;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0010_01_1_0_0_0) begin
      n_miss++; $display("FAIL midrun_pre: got %b want %b", outs(), 10'b0010_01_1_0_0_0);
    end
    rst_n = 1'b0;
    tick(1);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL reset_mid_run: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
    rst_n = 1'b1;
    continuous = 1'b0;
    sens = 4'b0101;
    tick(10);
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    start = 1'b1;
    tick(7);
    start = 1'b0;
    tick(49);
    n_vec++;
    if (outs() !== 10'b0001_00_1_0_0_0) begin
      n_miss++; $display("FAIL wd_before: got %b want %b", outs(), 10'b0001_00_1_0_0_0);
    end
    tick(1);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_1) begin
      n_miss++; $display("FAIL wd_fault: got %b want %b", outs(), 10'b0000_00_0_0_0_1);
    end
    stop_resume = 1'b1;
    tick(7);
    n_vec++;
    if (outs() !== 10'b0000_00_0_0_0_0) begin
      n_miss++; $display("FAIL fault_clear: got %b want %b", outs(), 10'b0000_00_0_0_0_0);
    end
    stop_resume = 1'b0;
    tick(10);
  endtask
`endif

  initial begin
    test_reset();
    test_single_cycle();
    test_no_home();
    test_pause();
    test_continuous();
    test_reset_mid_run();
`ifdef SEQ_TIMEOUT_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
